fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter IFB_DEPTH, default 4, number of entries; power of two, >= 2.
REQ-002 SHALL have parameter IFB_WIDTH, default 38, entry width in bits.
REQ-003 SHALL have port s_clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port s_reset_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_flush_i  input  1  pipeline redirect; discard all entries.
REQ-006 SHALL have port s_push_i  input  1  fetch stage presents a new entry.
REQ-007 SHALL have port s_push_data_i  input  IFB_WIDTH  entry: [31:0] instruction word, [34:32] fetch status (FETCH_VALID=0, FETCH_BSERR=1, FETCH_DISCR=4, FETCH_INCER=5, FETCH_INUCE=6), [35] predicted-taken, [37:36] reserved.
REQ-008 SHALL have port s_pop_i  input  1  decode stage consumes the head entry.
REQ-009 SHALL have port s_pop_data_o  output  IFB_WIDTH  head entry.
REQ-010 SHALL have port s_valid_o  output  1  buffer non-empty.
REQ-011 SHALL have port s_full_o  output  1  count == IFB_DEPTH.
REQ-012 SHALL have port s_afull_o  output  1  count >= IFB_DEPTH-1; fetch stops issuing new requests.
REQ-013 SHALL have port s_count_o  output  clog2(IFB_DEPTH)+1  current occupancy.
REQ-014 SHALL have port s_ferr_o  output  1  s_valid_o and head status [34:32] != FETCH_VALID.
REQ-015 SHALL have port s_ovf_o  output  1  sticky overflow flag.

Function
REQ-016 SHALL store entries in FIFO order in a circular array; read and write pointers wrap modulo IFB_DEPTH.
REQ-017 SHALL accept a push when s_push_i=1 and (s_full_o=0 or an accepted pop occurs in the same cycle); entry copied bit-exact, reserved bits included.
REQ-018 SHALL accept a pop when s_pop_i=1 and s_valid_o=1; pop while empty is ignored, no state change.
REQ-019 SHALL keep count unchanged on simultaneous accepted push and pop; +1 on push only; -1 on pop only.
REQ-020 SHALL have one-cycle latency: entry pushed in cycle N visible on s_pop_data_o and s_valid_o=1 in cycle N+1; no same-cycle bypass.
REQ-021 SHALL drive s_pop_data_o combinationally from the head slot when s_valid_o=1, and all zeros when empty.
REQ-022 SHALL, on push while full without accepted pop, drop the entry, leave contents unchanged, and set s_ovf_o=1 from the next cycle.
REQ-023 SHALL hold s_ovf_o until reset or flush.
REQ-024 SHALL, when s_flush_i=1, zero both pointers, count and s_ovf_o in the next cycle; push and pop in the flush cycle are discarded.
REQ-025 SHALL derive s_full_o, s_afull_o, s_valid_o, s_ferr_o from registered count/pointers only (no combinational path from s_push_i/s_pop_i).
REQ-026 SHALL not require storage contents to be reset; only pointers, count and s_ovf_o are reset.

Reset
REQ-027 SHALL, with s_reset_i=1 at a clock edge, set pointers=0, count=0, s_ovf_o=0; hence s_valid_o=0, s_full_o=0, s_afull_o=0, s_ferr_o=0, s_pop_data_o=0.
REQ-028 SHALL give reset priority over flush, push and pop in the same cycle, including mid-operation with a full buffer.

Verification
REQ-029 SHALL cover: push 0x00000013 status 0 in cycle 0 -> cycle 1 s_valid_o=1, s_count_o=1, s_pop_data_o[31:0]=0x00000013, s_ferr_o=0.
REQ-030 SHALL cover: 4 pushes, no pop (depth 4) -> s_afull_o=1 after 3rd, s_full_o=1 after 4th; 5th push dropped, s_ovf_o=1, pops return pushes 1..4 in order.
REQ-031 SHALL cover: full buffer, push and pop same cycle -> s_count_o stays 4, s_ovf_o=0, new entry emerges after 3 further pops.
REQ-032 SHALL cover: 3 entries, s_flush_i=1 with s_push_i=1 -> next cycle s_count_o=0, s_valid_o=0, s_pop_data_o=0, pushed entry absent.
REQ-033 SHALL cover: push entry with status FETCH_BSERR (1) into empty buffer -> next cycle s_ferr_o=1; after pop s_ferr_o=0.
REQ-034 SHALL cover: 10 push/pop iterations through depth 4 (pointer wrap) and s_reset_i=1 while full -> data order preserved across wrap; after reset all outputs zero.

Source files
------------

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: a circular FIFO between the fetch and decode stages.
// Status flags come only from registered pointers/count, so nothing in them depends on this cycle's push/pop.
module fetch_buffer #(
   parameter int IFB_DEPTH = 4,
   parameter int IFB_WIDTH = 38
) (
   input  logic                         s_clk_i,
   input  logic                         s_reset_i,
   input  logic                         s_flush_i,
   input  logic                         s_push_i,
   input  logic [IFB_WIDTH-1:0]         s_push_data_i,
   input  logic                         s_pop_i,
   output logic [IFB_WIDTH-1:0]         s_pop_data_o,
   output logic                         s_valid_o,
   output logic                         s_full_o,
   output logic                         s_afull_o,
   output logic [$clog2(IFB_DEPTH):0]   s_count_o,
   output logic                         s_ferr_o,
   output logic                         s_ovf_o
);

   localparam int PTR_W = $clog2(IFB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [IFB_WIDTH-1:0] mem_q [IFB_DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 ovf_q, ovf_d;
   logic                 wr_en_d;
   logic                 push_ok, pop_ok;
   logic [IFB_WIDTH-1:0] head_data;

   // Handshake: a pop is taken when s_pop_i and s_valid_o are both high; a push is
   // taken when s_push_i is high and the buffer is not full, or a pop is taken in the
   // same cycle. A refused push is dropped and raises the sticky overflow flag.
   assign s_valid_o = (count_q != '0);
   assign s_full_o  = (count_q == CNT_W'(IFB_DEPTH));
   assign s_afull_o = (count_q >= CNT_W'(IFB_DEPTH - 1));
   assign s_count_o = count_q;
   assign s_ovf_o   = ovf_q;

   assign pop_ok  = s_pop_i && s_valid_o;
   assign push_ok = s_push_i && (!s_full_o || pop_ok);

   assign head_data    = mem_q[rd_ptr_q];
   assign s_pop_data_o = s_valid_o ? head_data : '0;
   assign s_ferr_o     = s_valid_o && (head_data[34:32] != 3'd0);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      wr_en_d  = 1'b0;
      if (s_flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         if (push_ok) begin
            wr_en_d  = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
         end
         if (s_push_i && !push_ok) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (s_reset_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is never reset; the pointers and count decide what is visible.
   always_ff @(posedge s_clk_i) begin
      if (!s_reset_i && wr_en_d) begin
         mem_q[wr_ptr_q] <= s_push_data_i;
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (depth 4, width 38).
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
module tb_fetch_buffer;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        push;
   logic [37:0] push_data;
   logic        pop;
   logic [37:0] pop_data;
   logic        valid;
   logic        full;
   logic        afull;
   logic [2:0]  count;
   logic        ferr;
   logic        ovf;

   int checks = 0;
   int errors = 0;
   logic [37:0] ent [10];

   fetch_buffer #(.IFB_DEPTH(4), .IFB_WIDTH(38)) dut (
      .s_clk_i       (clk),
      .s_reset_i     (reset),
      .s_flush_i     (flush),
      .s_push_i      (push),
      .s_push_data_i (push_data),
      .s_pop_i       (pop),
      .s_pop_data_o  (pop_data),
      .s_valid_o     (valid),
      .s_full_o      (full),
      .s_afull_o     (afull),
      .s_count_o     (count),
      .s_ferr_o      (ferr),
      .s_ovf_o       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_valid"}, valid, 1'b0);
      chk({tag, "_count"}, count, 3'd0);
      chk({tag, "_full"},  full,  1'b0);
      chk({tag, "_afull"}, afull, 1'b0);
      chk({tag, "_ferr"},  ferr,  1'b0);
      chk({tag, "_data"},  pop_data, 38'd0);
   endtask

   task automatic push_one(input logic [37:0] d);
      push = 1'b1;
      push_data = d;
      step();
      push = 1'b0;
   endtask

   initial begin
      // Distinct entries with reserved and predicted-taken bits exercised, status FETCH_VALID.
      ent[0] = 38'h00_A000_0000;
      ent[1] = 38'h18_A000_0001;
      ent[2] = 38'h20_A000_0002;
      ent[3] = 38'h38_A000_0003;
      ent[4] = 38'h00_A000_0004;
      ent[5] = 38'h08_A000_0005;
      ent[6] = 38'h30_A000_0006;
      ent[7] = 38'h28_A000_0007;
      ent[8] = 38'h10_A000_0008;
      ent[9] = 38'h38_A000_0009;

      reset = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0; push_data = '0;
      step();
      step();
      reset = 1'b0;
      chk_empty("reset");
      chk("reset_ovf", ovf, 1'b0);

      // Single push: not visible in the push cycle, visible the next.
      push = 1'b1;
      push_data = 38'h00_0000_0013;
      #1;
      chk("nobypass_valid", valid, 1'b0);
      step();
      push = 1'b0;
      chk("p1_valid", valid, 1'b1);
      chk("p1_count", count, 3'd1);
      chk("p1_data",  pop_data[31:0], 32'h0000_0013);
      chk("p1_ferr",  ferr, 1'b0);
      pop = 1'b1;
      step();
      pop = 1'b0;
      chk("p1_pop_valid", valid, 1'b0);

      // Fill to full, then overflow.
      push_one(ent[0]);
      chk("fill1_afull", afull, 1'b0);
      push_one(ent[1]);
      chk("fill2_count", count, 3'd2);
      chk("fill2_afull", afull, 1'b0);
      push_one(ent[2]);
      chk("fill3_afull", afull, 1'b1);
      chk("fill3_full",  full,  1'b0);
      push_one(ent[3]);
      chk("fill4_full",  full,  1'b1);
      chk("fill4_count", count, 3'd4);
      chk("fill4_ovf",   ovf,   1'b0);
      push_one(ent[9]);
      chk("ovf_flag",  ovf,   1'b1);
      chk("ovf_count", count, 3'd4);
      chk("ovf_head",  pop_data, ent[0]);
      pop = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain_%0d", k), pop_data, ent[k]);
         step();
      end
      pop = 1'b0;
      chk_empty("drained");
      chk("ovf_sticky", ovf, 1'b1);

      // Pop while empty is ignored.
      pop = 1'b1;
      step();
      pop = 1'b0;
      chk("empty_pop_count", count, 3'd0);
      chk("empty_pop_ovf",   ovf,   1'b1);

      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_ovf", ovf, 1'b0);

      // Full buffer with simultaneous push and pop.
      for (int k = 0; k < 4; k++) push_one(ent[k]);
      push = 1'b1; pop = 1'b1; push_data = ent[4];
      step();
      push = 1'b0;
      chk("pp_count", count, 3'd4);
      chk("pp_ovf",   ovf,   1'b0);
      chk("pp_full",  full,  1'b1);
      for (int k = 1; k < 4; k++) begin
         chk($sformatf("pp_head_%0d", k), pop_data, ent[k]);
         step();
      end
      chk("pp_new_head", pop_data, ent[4]);
      chk("pp_count1",   count, 3'd1);
      step();
      pop = 1'b0;
      chk("pp_empty", valid, 1'b0);

      // Flush with a push in the same cycle.
      for (int k = 5; k < 8; k++) push_one(ent[k]);
      chk("pre_flush_count", count, 3'd3);
      flush = 1'b1; push = 1'b1; push_data = ent[8];
      step();
      flush = 1'b0; push = 1'b0;
      chk_empty("flush");
      step();
      chk("flush_push_absent", count, 3'd0);

      // Error status at the head.
      push_one(38'h01_0000_0BAD);
      chk("bserr_ferr", ferr, 1'b1);
      pop = 1'b1;
      step();
      pop = 1'b0;
      chk("bserr_pop_ferr", ferr, 1'b0);
      push_one(38'h0D_0000_0BAD);
      chk("incer_ferr", ferr, 1'b1);
      chk("incer_data", pop_data, 38'h0D_0000_0BAD);
      pop = 1'b1;
      step();
      pop = 1'b0;

      // Streaming through ten entries so the pointers wrap.
      push_one(ent[0]);
      push = 1'b1; pop = 1'b1;
      for (int k = 1; k < 10; k++) begin
         push_data = ent[k];
         chk($sformatf("wrap_head_%0d", k - 1), pop_data, ent[k-1]);
         step();
         chk($sformatf("wrap_count_%0d", k), count, 3'd1);
      end
      push = 1'b0;
      chk("wrap_head_9", pop_data, ent[9]);
      step();
      pop = 1'b0;
      chk("wrap_empty", valid, 1'b0);

      // Reset while full and overflowed, with push/pop/flush requests pending.
      for (int k = 0; k < 5; k++) push_one(ent[k]);
      chk("pre_reset_full", full, 1'b1);
      chk("pre_reset_ovf",  ovf,  1'b1);
      reset = 1'b1; push = 1'b1; pop = 1'b1; flush = 1'b1; push_data = ent[9];
      step();
      reset = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
      chk_empty("midreset");
      chk("midreset_ovf", ovf, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
